// File: rtl/btn_event_fifo.sv
// rtl/btn_event_fifo.sv - button rise events tagged with a switch snapshot, queued in a show-ahead FIFO
module btn_event_fifo #(
    parameter int DEPTH = 8,
    parameter int BTN_W = 5,
    parameter int SW_W  = 16
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [BTN_W-1:0]           i_btn_ok,
    input  logic [SW_W-1:0]            i_sw_ok,
    output logic                       o_evt_valid,
    input  logic                       i_evt_ready,
    output logic [BTN_W-1:0]           o_evt_mask,
    output logic [SW_W-1:0]            o_evt_sw,
    output logic [$clog2(DEPTH):0]     o_level,
    output logic                       o_overflow,
    output logic [7:0]                 o_drop_cnt,
    input  logic                       i_clr_ovf
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int EW = BTN_W + SW_W;

    logic [BTN_W-1:0] r_btn_prev;
    logic [EW-1:0]    r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_level;
    logic             r_overflow;
    logic [7:0]       r_drop_cnt;

    logic [BTN_W-1:0] w_rise;
    logic             w_push;
    logic             w_pop;
    logic             w_full;
    logic             w_wr_en;
    logic             w_drop;

    assign w_rise  = i_btn_ok & ~r_btn_prev;
    assign w_push  = |w_rise;
    assign w_pop   = (r_level != '0) & i_evt_ready;
    assign w_full  = (r_level == LW'(DEPTH));
    // When full, a same-cycle pop frees the head slot so the push can proceed.
    assign w_wr_en = w_push & (~w_full | w_pop);
    assign w_drop  = w_push & w_full & ~w_pop;

    always_ff @(posedge i_clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= {w_rise, i_sw_ok};
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_btn_prev <= '1;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            r_btn_prev <= i_btn_ok;
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_wr_en && !w_pop) begin
                r_level <= r_level + LW'(1);
            end else if (w_pop && !w_wr_en) begin
                r_level <= r_level - LW'(1);
            end
            // A drop in the same cycle as a clear leaves exactly one drop recorded.
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (i_clr_ovf) begin
                    r_drop_cnt <= 8'd1;
                end else if (r_drop_cnt != 8'hFF) begin
                    r_drop_cnt <= r_drop_cnt + 8'd1;
                end
            end else if (i_clr_ovf) begin
                r_overflow <= 1'b0;
                r_drop_cnt <= '0;
            end
        end
    end

    assign o_evt_valid = (r_level != '0);
    assign {o_evt_mask, o_evt_sw} = r_mem[r_rd_ptr];
    assign o_level     = r_level;
    assign o_overflow  = r_overflow;
    assign o_drop_cnt  = r_drop_cnt;
endmodule

// File: tb/tb_btn_event_fifo.sv
// tb/tb_btn_event_fifo.sv - directed self-checking bench for btn_event_fifo
module tb_btn_event_fifo;
    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  btn_ok;
    logic [15:0] sw_ok;
    logic        evt_valid;
    logic        evt_ready;
    logic [4:0]  evt_mask;
    logic [15:0] evt_sw;
    logic [3:0]  level;
    logic        overflow;
    logic [7:0]  drop_cnt;
    logic        clr_ovf;

    int total = 0;
    int bad   = 0;

    btn_event_fifo #(.DEPTH(8), .BTN_W(5), .SW_W(16)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_btn_ok    (btn_ok),
        .i_sw_ok     (sw_ok),
        .o_evt_valid (evt_valid),
        .i_evt_ready (evt_ready),
        .o_evt_mask  (evt_mask),
        .o_evt_sw    (evt_sw),
        .o_level     (level),
        .o_overflow  (overflow),
        .o_drop_cnt  (drop_cnt),
        .i_clr_ovf   (clr_ovf)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse(input logic [4:0] m, input logic [15:0] s);
        btn_ok = m;
        sw_ok  = s;
        tick();
        btn_ok = '0;
        tick();
    endtask

    function automatic logic [4:0] pat_mask(input int i);
        logic [4:0] one;
        one = 5'b00001;
        return one << (i % 5);
    endfunction

    initial begin
        rst = 1'b1; btn_ok = '0; sw_ok = '0; evt_ready = 1'b0; clr_ovf = 1'b0;
        tick(); tick();
        rst = 1'b0;
        check("rst_valid", 32'(evt_valid), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_drop", 32'(drop_cnt), 32'd0);
        tick();

        // single pulse, no read latency on the head
        btn_ok = 5'b00001; sw_ok = 16'hA5A5;
        tick();
        btn_ok = '0;
        check("t1_valid", 32'(evt_valid), 32'd1);
        check("t1_mask", 32'(evt_mask), 32'h01);
        check("t1_sw", 32'(evt_sw), 32'hA5A5);
        check("t1_level", 32'(level), 32'd1);
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
        check("t1_pop_valid", 32'(evt_valid), 32'd0);

        // held multi-bit press gives one entry
        btn_ok = 5'b10100; sw_ok = 16'h1234;
        tick(); tick(); tick();
        btn_ok = '0;
        tick();
        check("t2_level", 32'(level), 32'd1);
        check("t2_mask", 32'(evt_mask), 32'h14);
        check("t2_sw", 32'(evt_sw), 32'h1234);
        evt_ready = 1'b1; tick(); evt_ready = 1'b0;
        check("t2_level0", 32'(level), 32'd0);

        // button held across reset
        rst = 1'b1; btn_ok = 5'b00001;
        tick(); tick();
        rst = 1'b0;
        tick(); tick(); tick();
        check("t3_held_valid", 32'(evt_valid), 32'd0);
        check("t3_held_level", 32'(level), 32'd0);
        btn_ok = '0; tick();
        btn_ok = 5'b00001; sw_ok = 16'h0F0F; tick();
        btn_ok = '0;
        check("t3_level", 32'(level), 32'd1);
        check("t3_mask", 32'(evt_mask), 32'h01);
        evt_ready = 1'b1; tick(); evt_ready = 1'b0;

        // fill, overflow by two, drain in order
        for (int i = 0; i < 8; i++) pulse(pat_mask(i), 16'h1000 + 16'(i));
        check("t4_full_level", 32'(level), 32'd8);
        check("t4_no_ovf", 32'(overflow), 32'd0);
        pulse(5'b11111, 16'h2000);
        pulse(5'b11111, 16'h2001);
        check("t4_ovf", 32'(overflow), 32'd1);
        check("t4_drop", 32'(drop_cnt), 32'd2);
        check("t4_level", 32'(level), 32'd8);
        evt_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("t4_drain_valid%0d", i), 32'(evt_valid), 32'd1);
            check($sformatf("t4_drain_mask%0d", i), 32'(evt_mask), 32'(pat_mask(i)));
            check($sformatf("t4_drain_sw%0d", i), 32'(evt_sw), 32'h1000 + 32'(i));
            tick();
        end
        evt_ready = 1'b0;
        check("t4_empty", 32'(evt_valid), 32'd0);

        // full with simultaneous push and pop
        for (int i = 0; i < 8; i++) pulse(pat_mask(i), 16'h1000 + 16'(i));
        btn_ok = 5'b11111; sw_ok = 16'hBEEF; evt_ready = 1'b1;
        tick();
        btn_ok = '0; evt_ready = 1'b0;
        check("t5_level", 32'(level), 32'd8);
        check("t5_drop", 32'(drop_cnt), 32'd2);
        tick();
        evt_ready = 1'b1;
        for (int i = 1; i < 8; i++) begin
            check($sformatf("t5_sw%0d", i), 32'(evt_sw), 32'h1000 + 32'(i));
            tick();
        end
        check("t5_last_mask", 32'(evt_mask), 32'h1F);
        check("t5_last_sw", 32'(evt_sw), 32'hBEEF);
        tick();
        evt_ready = 1'b0;
        check("t5_empty", 32'(level), 32'd0);

        // pointer wrap over 20 push/pop cycles
        for (int k = 0; k < 20; k++) begin
            btn_ok = pat_mask(k); sw_ok = 16'h3000 + 16'(k);
            tick();
            btn_ok = '0;
            check($sformatf("t5_wrap_sw%0d", k), 32'(evt_sw), 32'h3000 + 32'(k));
            check($sformatf("t5_wrap_mask%0d", k), 32'(evt_mask), 32'(pat_mask(k)));
            evt_ready = 1'b1; tick(); evt_ready = 1'b0;
            check($sformatf("t5_wrap_lvl%0d", k), 32'(level), 32'd0);
        end

        // drop counter saturation and clear
        for (int i = 0; i < 8; i++) pulse(5'b00010, 16'h4000 + 16'(i));
        for (int i = 0; i < 253; i++) pulse(5'b00100, 16'h5000);
        check("t6_sat", 32'(drop_cnt), 32'd255);
        for (int i = 0; i < 3; i++) pulse(5'b00100, 16'h5001);
        check("t6_sat_hold", 32'(drop_cnt), 32'd255);
        check("t6_level", 32'(level), 32'd8);
        clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
        check("t6_clr_ovf", 32'(overflow), 32'd0);
        check("t6_clr_drop", 32'(drop_cnt), 32'd0);
        tick();
        clr_ovf = 1'b1; btn_ok = 5'b01000; sw_ok = 16'h6000;
        tick();
        clr_ovf = 1'b0; btn_ok = '0;
        check("t6_clr_drop_ovf", 32'(overflow), 32'd1);
        check("t6_clr_drop_cnt", 32'(drop_cnt), 32'd1);
        check("t6_head_sw", 32'(evt_sw), 32'h4000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
